pipe_scroller: RTL and testbench
================================

Name: pipe_scroller

Overview:
- Consumer end of the pipe-speed tick. Each one-cycle shift tick scrolls the pipe playfield one column left.
- Synthesises the incoming right-hand column: pipe columns with a pseudo-random gap, alternating with empty spacing columns.
- Reports a collision with the bird's cell and a one-cycle score pulse when a pipe clears the bird column.
- Sits between the pipe tick generator and the LED-matrix driver / game FSM.

Parameters:
ROWS, 16, playfield rows (row 0 = top)
COLS, 16, playfield columns (COLS-1 = entry/right, 0 = exit/left)
GAP, 4, open rows per pipe
PIPE_W, 2, columns per pipe
SPACING, 6, empty columns between pipes
BIRD_COL, 3, fixed bird column
SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
pause  in  1  freezes scrolling and LFSR
shift_tick  in  1  one-cycle pulse from the pipe tick generator
bird_row  in  $clog2(ROWS)  current bird row
pipe_grid  out  [ROWS-1:0][COLS-1:0]  1 = pipe pixel; registered
collide  out  1  bird cell occupied; registered
score_pulse  out  1  one-cycle pulse, pipe passed bird
gap_top  out  $clog2(ROWS)  gap top row of the pipe currently being emitted (debug)

Behaviour:
- Reset (dominates everything): pipe_grid=0, collide=0, score_pulse=0, gap_top=0, LFSR=SEED, state=GEN_GAP, cnt=SPACING.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clk when !pause.
- Gap mapping:
  - raw = lfsr[3:0].
  - g = raw>(ROWS-GAP-1) ? raw-(ROWS-GAP-1) : raw; if g==0 then g=1.
  - Defaults give g in [1,11]; row 0 and row ROWS-1 are always pipe.
- tick = shift_tick & !pause. A tick during pause is dropped, not queued.
- On a tick edge:
  - grid[r][c] <= grid[r][c+1] for c < COLS-1; column 0 is discarded.
  - grid[r][COLS-1] <= incoming column (below).
  - New grid is visible the cycle after the edge.
- Generator FSM (advances on ticks only):
  - GEN_GAP:
    - Incoming column is all zeros; cnt--.
    - If cnt reaches 0: go to GEN_PIPE, wcnt=PIPE_W, latch gap_top=g from the current LFSR.
  - GEN_PIPE:
    - Incoming column is 1 for every row except gap_top..gap_top+GAP-1; wcnt--.
    - If wcnt reaches 0: go to GEN_GAP, cnt=SPACING.
  - Period is PIPE_W+SPACING ticks.
  - After reset, ticks 1–6 shift in zeros, ticks 7–8 shift in the first pipe, ticks 15–16 the second pipe.
- score_pulse:
  - Registered. Set at a tick edge where the pre-shift column BIRD_COL is nonzero and the pre-shift column BIRD_COL+1 is zero.
  - Cleared on every other edge, so it is high exactly one cycle.
- collide:
  - collide <= grid[bird_row][BIRD_COL] on every non-reset edge, including during pause. One-cycle latency after the grid.
  - bird_row >= ROWS yields collide=0.
- Reset mid-pipe: discards the partial pipe; generation restarts at GEN_GAP with cnt=SPACING.

Decomposition:
- pipe_pkg contains:
  - ROWS/COLS defaults
  - gen_state_t enum {GEN_GAP, GEN_PIPE}
  - LFSR width and tap constant
  - gap-mapping function
- Sub-module pipe_lfsr: clk, reset, en, seed parameter, 8-bit state out.
- The grid shift, FSM and score/collide logic stay in pipe_scroller.

Test Plan:
1. Reset, then 6 ticks -> pipe_grid all zero, score_pulse never high. Tick 7 -> column 15 = pipe mask of latched gap_top (rows gap_top..gap_top+3 zero, others 1), columns 0–14 zero.
2. 21 ticks from reset, 10 idle clocks between ticks -> first pipe occupies column 3 after ticks 19–20. score_pulse high for exactly one cycle after tick 21, never otherwise.
3. Hold pause=1 with 5 shift_tick pulses -> pipe_grid and LFSR unchanged. Release, 1 tick -> exactly one column shift.
4. After tick 19 (pipe in column 3): bird_row=0 -> collide=1 one cycle later; bird_row=gap_top -> collide=0.
5. Assert reset at tick 8 (mid-pipe) -> next cycle grid=0, state GEN_GAP. First pipe re-enters only on the 7th tick after reset.
6. Run 2000 ticks vs. reference model (same SEED, same tick timing) -> grid matches every cycle; every gap_top in [1,11]; pipe period 8 ticks.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe playfield: default geometry, generator
// states, LFSR constants and the LFSR-to-gap mapping.
package pipe_pkg;

    localparam int ROWS_DEF = 16;
    localparam int COLS_DEF = 16;

    // 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
    localparam int                LFSR_W    = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [0:0] {
        GEN_GAP  = 1'b0,
        GEN_PIPE = 1'b1
    } gen_state_t;

    // Fold a 4-bit random value into a legal gap top row so that the top
    // and bottom rows are always pipe.
    function automatic int unsigned gap_map(input logic [3:0] raw,
                                            input int unsigned rows,
                                            input int unsigned gap);
        int unsigned lim;
        int unsigned g;
        lim = rows - gap - 1;
        if (32'(raw) > lim)
            g = 32'(raw) - lim;
        else
            g = 32'(raw);
        if (g == 0)
            g = 1;
        return g;
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the gap position source.
module pipe_lfsr
    import pipe_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Shift left, feedback (XOR of tapped bits) enters at bit 0
    always_comb begin
        state_d = state_q;
        if (en)
            state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
    end

    // State register, reloaded with the seed on reset
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= SEED;
        else
            state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe playfield: shifts one column left per tick, synthesises
// the entering column, and reports bird collision and pipe-passed score.
module pipe_scroller
    import pipe_pkg::*;
#(
    parameter int                ROWS     = ROWS_DEF,
    parameter int                COLS     = COLS_DEF,
    parameter int                GAP      = 4,
    parameter int                PIPE_W   = 2,
    parameter int                SPACING  = 6,
    parameter int                BIRD_COL = 3,
    parameter logic [LFSR_W-1:0] SEED     = 8'hA5,
    localparam int               RW       = $clog2(ROWS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pause,
    input  logic                       shift_tick,
    input  logic [RW-1:0]              bird_row,
    output logic [ROWS-1:0][COLS-1:0]  pipe_grid,
    output logic                       collide,
    output logic                       score_pulse,
    output logic [RW-1:0]              gap_top
);

    logic                      tick;
    logic [LFSR_W-1:0]         lfsr;
    logic                      unused_lfsr_hi;
    gen_state_t                state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [7:0]                wcnt_q, wcnt_d;
    logic [RW-1:0]             gap_top_q, gap_top_d;
    logic [ROWS-1:0][COLS-1:0] grid_q, grid_d;
    logic [ROWS-1:0]           incoming;
    logic [ROWS-1:0]           pipe_col;
    logic [ROWS-1:0]           bird_col_bits;
    logic [ROWS-1:0]           next_col_bits;
    logic                      bird_ok;
    logic                      score_d;
    logic                      collide_d;

    // A tick arriving while paused is simply lost
    assign tick = shift_tick & ~pause;

    pipe_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (~pause),
        .state (lfsr)
    );

    // Only the low nibble drives the gap position
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:4];

    // Per-row wiring: pipe mask, column shift, and bird-column taps
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        localparam logic [RW:0] ROW_IDX = (RW+1)'(gi);
        assign pipe_col[gi] = !(({1'b0, gap_top_q} <= ROW_IDX) &&
                                (ROW_IDX < ({1'b0, gap_top_q} + (RW+1)'(GAP))));
        assign grid_d[gi] = tick ? {incoming[gi], grid_q[gi][COLS-1:1]} : grid_q[gi];
        assign bird_col_bits[gi] = grid_q[gi][BIRD_COL];
        assign next_col_bits[gi] = grid_q[gi][BIRD_COL+1];
    end

    // Rows beyond the playfield can only be addressed when ROWS is not a power of two
    if ((1 << RW) > ROWS) begin : g_row_chk
        localparam logic [RW-1:0] ROWS_W = RW'(ROWS);
        assign bird_ok = bird_row < ROWS_W;
    end else begin : g_row_all
        assign bird_ok = 1'b1;
    end

    // Generator FSM: SPACING empty columns, then PIPE_W pipe columns
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        gap_top_d = gap_top_q;
        incoming  = '0;
        if (tick) begin
            case (state_q)
                GEN_GAP: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d   = GEN_PIPE;
                        wcnt_d    = 8'(PIPE_W);
                        gap_top_d = RW'(gap_map(lfsr[3:0], ROWS, GAP));
                    end
                end
                GEN_PIPE: begin
                    incoming = pipe_col;
                    wcnt_d   = wcnt_q - 8'd1;
                    if (wcnt_q == 8'd1) begin
                        state_d = GEN_GAP;
                        cnt_d   = 8'(SPACING);
                    end
                end
                default: state_d = GEN_GAP;
            endcase
        end
    end

    // Score when the trailing pipe column is about to leave the bird column
    assign score_d   = tick & (|bird_col_bits) & ~(|next_col_bits);
    assign collide_d = bird_ok & grid_q[bird_row][BIRD_COL];

    // All registered state; collide keeps tracking even while paused
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= GEN_GAP;
            cnt_q       <= 8'(SPACING);
            wcnt_q      <= '0;
            gap_top_q   <= '0;
            grid_q      <= '0;
            score_pulse <= 1'b0;
            collide     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            gap_top_q   <= gap_top_d;
            grid_q      <= grid_d;
            score_pulse <= score_d;
            collide     <= collide_d;
        end
    end

    assign pipe_grid = grid_q;
    assign gap_top   = gap_top_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller with a tick-history reference model.
module tb_pipe_scroller;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pause = 1'b0;
    logic             shift_tick = 1'b0;
    logic [3:0]       bird_row = 4'd0;
    logic [15:0][15:0] pipe_grid;
    logic             collide;
    logic             score_pulse;
    logic [3:0]       gap_top;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pipe_scroller dut (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .shift_tick  (shift_tick),
        .bird_row    (bird_row),
        .pipe_grid   (pipe_grid),
        .collide     (collide),
        .score_pulse (score_pulse),
        .gap_top     (gap_top)
    );

    // ---------------- reference model ----------------
    // hist[k] is the column that entered k ticks ago (bit r = row r);
    // playfield column c therefore holds hist[15-c].
    logic [7:0]  lfsr_m;
    logic [15:0] hist [16];
    int          tcount;
    logic [3:0]  gap_m;
    logic        score_m;
    logic        collide_m;
    int          phase_v;
    logic [15:0] col_v;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [3:0] map_gap(input logic [7:0] s);
        int raw;
        raw = int'(s[3:0]);
        if (raw > 11) raw = raw - 11;
        if (raw == 0) raw = 1;
        return 4'(raw);
    endfunction

    function automatic logic [15:0] mask_for(input logic [3:0] g);
        logic [15:0] m;
        for (int r = 0; r < 16; r++)
            m[r] = !(r >= int'(g) && r < int'(g) + 4);
        return m;
    endfunction

    function automatic logic [15:0][15:0] model_grid();
        logic [15:0][15:0] g;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                g[r][c] = hist[15-c][r];
        return g;
    endfunction

    function automatic logic [15:0] dut_col(input int c);
        logic [15:0] v;
        for (int r = 0; r < 16; r++)
            v[r] = pipe_grid[r][c];
        return v;
    endfunction

    // Ticks since reset decide the column kind: phases 0-5 empty, 6-7 pipe
    always @(posedge clk) begin
        if (reset) begin
            lfsr_m    <= 8'hA5;
            tcount    <= 0;
            gap_m     <= 4'd0;
            score_m   <= 1'b0;
            collide_m <= 1'b0;
            for (int i = 0; i < 16; i++) hist[i] <= '0;
        end else begin
            collide_m <= hist[12][bird_row];
            if (!pause) lfsr_m <= lfsr_step(lfsr_m);
            if (shift_tick && !pause) begin
                phase_v = tcount % 8;
                if (phase_v == 5) gap_m <= map_gap(lfsr_m);
                col_v = (phase_v >= 6) ? mask_for(gap_m) : 16'h0000;
                for (int i = 15; i > 0; i--) hist[i] <= hist[i-1];
                hist[0] <= col_v;
                tcount  <= tcount + 1;
                score_m <= (hist[12] != 16'h0) && (hist[11] == 16'h0);
            end else begin
                score_m <= 1'b0;
            end
        end
    end

    logic [3:0] first_gap;

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (pipe_grid !== '0) begin
            mismatched++;
            $display("FAIL reset_grid: got %h want 0", pipe_grid);
        end
        compared++;
        if (collide !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_collide: got %b want 0", collide);
        end
        compared++;
        if (score_pulse !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_score: got %b want 0", score_pulse);
        end
        compared++;
        if (gap_top !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_gap_top: got %0d want 0", gap_top);
        end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_first_pipe();
        logic [15:0] low_cols;
        for (int k = 1; k <= 7; k++) begin
            repeat (10) begin
                @(negedge clk);
                compared++;
                if (score_pulse !== 1'b0) begin
                    mismatched++;
                    $display("FAIL first_idle_score: tick %0d got %b want 0", k, score_pulse);
                end
            end
            shift_tick = 1'b1;
            @(negedge clk);
            shift_tick = 1'b0;
            if (k <= 6) begin
                compared++;
                if (pipe_grid !== '0) begin
                    mismatched++;
                    $display("FAIL first_zero_grid: tick %0d got %h want 0", k, pipe_grid);
                end
            end
        end
        first_gap = gap_m;
        compared++;
        if (gap_top !== gap_m) begin
            mismatched++;
            $display("FAIL first_gap_top: got %0d want %0d", gap_top, gap_m);
        end
        compared++;
        if (gap_top < 4'd1 || gap_top > 4'd11) begin
            mismatched++;
            $display("FAIL first_gap_range: got %0d want 1..11", gap_top);
        end
        compared++;
        if (dut_col(15) !== mask_for(gap_m)) begin
            mismatched++;
            $display("FAIL first_col15: got %h want %h", dut_col(15), mask_for(gap_m));
        end
        compared++;
        if (pipe_grid[0][15] !== 1'b1 || pipe_grid[15][15] !== 1'b1) begin
            mismatched++;
            $display("FAIL first_edge_rows: got %b%b want 11", pipe_grid[0][15], pipe_grid[15][15]);
        end
        low_cols = '0;
        for (int r = 0; r < 16; r++) low_cols[r] = |pipe_grid[r][14:0];
        compared++;
        if (low_cols !== 16'h0) begin
            mismatched++;
            $display("FAIL first_low_cols: got %h want 0", low_cols);
        end
        $display("test_first_pipe done gap=%0d", gap_m);
    endtask

    task automatic test_collide();
        for (int k = 8; k <= 19; k++) begin
            repeat (10) begin
                @(negedge clk);
                compared++;
                if (score_pulse !== 1'b0) begin
                    mismatched++;
                    $display("FAIL collide_idle_score: tick %0d got %b want 0", k, score_pulse);
                end
            end
            shift_tick = 1'b1;
            @(negedge clk);
            shift_tick = 1'b0;
            compared++;
            if (pipe_grid !== model_grid()) begin
                mismatched++;
                $display("FAIL collide_grid: tick %0d got %h want %h", k, pipe_grid, model_grid());
            end
        end
        compared++;
        if (dut_col(3) !== mask_for(first_gap) || dut_col(4) !== mask_for(first_gap)) begin
            mismatched++;
            $display("FAIL collide_col3: got %h/%h want %h", dut_col(3), dut_col(4), mask_for(first_gap));
        end
        bird_row = 4'd0;
        @(negedge clk);
        compared++;
        if (collide !== 1'b1) begin
            mismatched++;
            $display("FAIL collide_row0: got %b want 1", collide);
        end
        bird_row = first_gap;
        @(negedge clk);
        compared++;
        if (collide !== 1'b0) begin
            mismatched++;
            $display("FAIL collide_gap_row: got %b want 0", collide);
        end
        $display("test_collide done");
    endtask

    task automatic test_score();
        int highs = 0;
        for (int k = 20; k <= 22; k++) begin
            repeat (10) begin
                @(negedge clk);
                compared++;
                if (score_pulse !== 1'b0) begin
                    mismatched++;
                    $display("FAIL score_idle: tick %0d got %b want 0", k, score_pulse);
                end
            end
            shift_tick = 1'b1;
            @(negedge clk);
            shift_tick = 1'b0;
            compared++;
            if (score_pulse !== (k == 21)) begin
                mismatched++;
                $display("FAIL score_after_tick: tick %0d got %b want %b", k, score_pulse, (k == 21));
            end
            if (score_pulse === 1'b1) highs++;
            if (k == 20) begin
                compared++;
                if (dut_col(3) !== mask_for(first_gap) || dut_col(4) !== 16'h0) begin
                    mismatched++;
                    $display("FAIL score_tail_cols: got %h/%h want %h/0", dut_col(3), dut_col(4), mask_for(first_gap));
                end
            end
        end
        compared++;
        if (highs != 1) begin
            mismatched++;
            $display("FAIL score_count: got %0d want 1", highs);
        end
        $display("test_score done");
    endtask

    task automatic test_pause();
        logic [15:0][15:0] snap;
        logic [15:0] shifted_ok;
        snap = model_grid();
        pause = 1'b1;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            shift_tick = 1'b1;
            @(negedge clk);
            shift_tick = 1'b0;
            compared++;
            if (pipe_grid !== snap) begin
                mismatched++;
                $display("FAIL pause_frozen: pulse %0d got %h want %h", p, pipe_grid, snap);
            end
        end
        @(negedge clk);
        pause = 1'b0;
        shift_tick = 1'b1;
        @(negedge clk);
        shift_tick = 1'b0;
        for (int r = 0; r < 16; r++) shifted_ok[r] = (pipe_grid[r][14:0] === snap[r][15:1]);
        compared++;
        if (shifted_ok !== 16'hFFFF) begin
            mismatched++;
            $display("FAIL pause_one_shift: rows ok %h want ffff", shifted_ok);
        end
        compared++;
        if (pipe_grid !== model_grid()) begin
            mismatched++;
            $display("FAIL pause_release_grid: got %h want %h", pipe_grid, model_grid());
        end
        $display("test_pause done");
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            repeat (2) @(negedge clk);
            shift_tick = 1'b1;
            @(negedge clk);
            shift_tick = 1'b0;
        end
        repeat (2) @(negedge clk);
        shift_tick = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        shift_tick = 1'b0;
        reset = 1'b0;
        compared++;
        if (pipe_grid !== '0 || gap_top !== 4'd0) begin
            mismatched++;
            $display("FAIL midreset_clear: grid %h gap %0d want 0/0", pipe_grid, gap_top);
        end
        for (int k = 1; k <= 7; k++) begin
            repeat (2) @(negedge clk);
            shift_tick = 1'b1;
            @(negedge clk);
            shift_tick = 1'b0;
            if (k <= 6) begin
                compared++;
                if (pipe_grid !== '0) begin
                    mismatched++;
                    $display("FAIL midreset_zero: tick %0d got %h want 0", k, pipe_grid);
                end
            end
        end
        compared++;
        if (pipe_grid[0][15] !== 1'b1 || dut_col(15) !== mask_for(gap_m)) begin
            mismatched++;
            $display("FAIL midreset_reentry: got %h want %h", dut_col(15), mask_for(gap_m));
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random_run();
        int eff = 0;
        int cyc = 0;
        int bad_before = mismatched;
        while (eff < 2000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            compared++;
            if (pipe_grid !== model_grid()) begin
                mismatched++;
                $display("FAIL run_grid: cycle %0d got %h want %h", cyc, pipe_grid, model_grid());
            end
            compared++;
            if (collide !== collide_m) begin
                mismatched++;
                $display("FAIL run_collide: cycle %0d got %b want %b", cyc, collide, collide_m);
            end
            compared++;
            if (score_pulse !== score_m) begin
                mismatched++;
                $display("FAIL run_score: cycle %0d got %b want %b", cyc, score_pulse, score_m);
            end
            compared++;
            if (gap_top !== gap_m) begin
                mismatched++;
                $display("FAIL run_gap_top: cycle %0d got %0d want %0d", cyc, gap_top, gap_m);
            end
            if (tcount >= 6) begin
                compared++;
                if (gap_top < 4'd1 || gap_top > 4'd11) begin
                    mismatched++;
                    $display("FAIL run_gap_range: cycle %0d got %0d want 1..11", cyc, gap_top);
                end
            end
            shift_tick = ($urandom_range(0, 2) == 0);
            pause      = ($urandom_range(0, 15) == 0);
            bird_row   = 4'($urandom_range(0, 15));
            if (shift_tick && !pause) eff++;
        end
        @(negedge clk);
        shift_tick = 1'b0;
        pause = 1'b0;
        compared++;
        if (eff < 2000) begin
            mismatched++;
            $display("FAIL run_budget: got %0d ticks want 2000", eff);
        end
        $display("test_random_run done ticks=%0d new_errors=%0d", eff, mismatched - bad_before);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_pipe();
        test_collide();
        test_score();
        test_pause();
        test_reset_mid();
        test_random_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
